// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the delta-sigma comb datapath.
// Range limits are used by the RTL parameter checks and by the bench.
package dsm_pkg;

  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 8;
  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 4;
  localparam int SHIFT_MIN = 0;
  localparam int SHIFT_MAX = 4;

  // Internal width: every difference stage can grow the magnitude by one bit.
  function automatic int iw(input int in_w, input int shift, input int order);
    return in_w + shift + order;
  endfunction

  function automatic logic signed [63:0] sat_reduce(input logic signed [63:0] value,
                                                    input int in_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (in_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (in_w - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/comb_stage.sv
// One difference stage: out = in - in delayed by DELAY accepted tokens.
// Output is one bit wider than the input so the subtraction is exact.
module comb_stage #(
  parameter int W     = 17,
  parameter int DELAY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic signed [W-1:0] in,
  input  logic                in_valid,
  output logic signed [W:0]   out,
  output logic                out_valid
);

  logic signed [W-1:0] dline [DELAY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DELAY; i++) dline[i] <= '0;
    end else if (clear) begin
      out       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DELAY; i++) dline[i] <= '0;
    end else begin
      out_valid <= in_valid;
      // History only moves on real tokens so idle clocks do not age it.
      if (in_valid) begin
        out      <= {in[W-1], in} - {dline[DELAY-1][W-1], dline[DELAY-1]};
        dline[0] <= in;
        for (int i = 1; i < DELAY; i++) dline[i] <= dline[i-1];
      end
    end
  end

endmodule

// File: rtl/comb_diff_n.sv
// N-order comb: y = diff_D^ORDER(x * 2^SHIFT), reduced to IN_W by saturate or wrap.
// Accepted sample at edge t appears with out_valid after edge t+ORDER.
module comb_diff_n
  import dsm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ORDER = 2,
  parameter int DELAY = 1,
  parameter int SHIFT = 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   clear,
  input  logic signed [IN_W-1:0] in,
  input  logic                   in_valid,
  input  logic                   sat_en,
  output logic signed [IN_W-1:0] out,
  output logic                   out_valid,
  output logic                   primed,
  output logic                   ovf
);

  localparam int IW = iw(IN_W, SHIFT, ORDER);
  localparam int PD = ORDER * DELAY;
  localparam int CW = $clog2(PD + 1);

  if (ORDER < ORDER_MIN || ORDER > ORDER_MAX || DELAY < DELAY_MIN || DELAY > DELAY_MAX ||
      SHIFT < SHIFT_MIN || SHIFT > SHIFT_MAX) begin : g_bad_param
    $error("comb_diff_n: parameter out of range");
  end

  logic signed [IW-1:0] st_dat [ORDER+1];
  logic [ORDER:0]       st_vld;
  logic                 accept;
  logic [CW-1:0]        cnt;

  assign accept    = in_valid & ~clear;
  assign st_vld[0] = accept;
  assign st_dat[0] = IW'(in) <<< SHIFT;

  for (genvar k = 1; k <= ORDER; k++) begin : g_stage
    localparam int W = IN_W + SHIFT + k - 1;
    logic signed [W:0] res;

    comb_stage #(.W(W), .DELAY(DELAY)) u_stage (
      .clk      (CLK),
      .reset    (reset),
      .clear    (clear),
      .in       (st_dat[k-1][W-1:0]),
      .in_valid (st_vld[k-1]),
      .out      (res),
      .out_valid(st_vld[k])
    );

    assign st_dat[k] = IW'(res);
  end

  logic signed [63:0]     clamped;
  logic signed [IN_W-1:0] reduced;
  logic                   clipped;

  always_comb begin
    clamped = sat_reduce(64'(st_dat[ORDER]), IN_W);
    reduced = sat_en ? clamped[IN_W-1:0] : st_dat[ORDER][IN_W-1:0];
    clipped = (IW'(reduced) != st_dat[ORDER]);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
    end else begin
      out_valid <= st_vld[ORDER];
      if (st_vld[ORDER]) begin
        out <= reduced;
        if (clipped) ovf <= 1'b1;
      end
      if (accept && cnt != CW'(PD)) cnt <= cnt + 1'b1;
    end
  end

  assign primed = (cnt == CW'(PD));

endmodule

// File: tb/tb_comb_diff_n.sv
// Bench for comb_diff_n: two instances (default and ORDER=1/DELAY=4/SHIFT=0)
// against a binomial-sum reference model with directed and random stimulus.
module tb_comb_diff_n;
  import dsm_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                a_clr, a_vld, a_sat, a_ov, a_pr, a_ovf;
  logic                b_clr, b_vld, b_sat, b_ov, b_pr, b_ovf;
  logic signed [W-1:0] a_in, a_out, b_in, b_out;

  comb_diff_n #(.IN_W(W), .ORDER(2), .DELAY(1), .SHIFT(1)) u_dut_a (
    .CLK(clk), .reset(rst), .clear(a_clr), .in(a_in), .in_valid(a_vld), .sat_en(a_sat),
    .out(a_out), .out_valid(a_ov), .primed(a_pr), .ovf(a_ovf)
  );

  comb_diff_n #(.IN_W(W), .ORDER(1), .DELAY(4), .SHIFT(0)) u_dut_b (
    .CLK(clk), .reset(rst), .clear(b_clr), .in(b_in), .in_valid(b_vld), .sat_en(b_sat),
    .out(b_out), .out_valid(b_ov), .primed(b_pr), .ovf(b_ovf)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int     ordv [2];
  int     dlyv [2];
  int     shfv [2];
  longint hist [2][$];
  longint pval [2][$];
  int     pdue [2][$];
  longint seen [2][$];
  bit     exp_vld [2];
  longint exp_out [2];
  bit     exp_ovf [2];
  int     exp_cnt [2];

  task automatic chk(input string tag, input logic signed [63:0] got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // y[n] = sum_j (-1)^j C(N,j) x[n - j*D], zero history before the first sample.
  function automatic longint ref_y(input int d);
    longint acc = 0;
    int     n   = hist[d].size() - 1;
    for (int j = 0; j <= ordv[d]; j++) begin
      int idx = n - j * dlyv[d];
      if (idx >= 0) acc += ((j % 2) ? -1 : 1) * binom(ordv[d], j) * hist[d][idx];
    end
    return acc;
  endfunction

  function automatic longint reduce(input longint v, input bit sat);
    longint m    = longint'(1) << W;
    longint half = m / 2;
    longint r;
    if (sat) return (v > half - 1) ? half - 1 : (v < -half) ? -half : v;
    r = v % m;
    if (r < 0) r += m;
    if (r >= half) r -= m;
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      hist[d].delete(); pval[d].delete(); pdue[d].delete();
      exp_vld[d] = 0; exp_out[d] = 0; exp_ovf[d] = 0; exp_cnt[d] = 0;
    end
  endtask

  // Predicts the state after edge number e given the inputs presented before it.
  task automatic model_step(input int d, input bit vld, input longint x, input bit sat,
                            input bit clr, input int e);
    longint full, red;
    exp_vld[d] = 0;
    if (clr) begin
      hist[d].delete(); pval[d].delete(); pdue[d].delete();
      exp_cnt[d] = 0; exp_ovf[d] = 0;
    end else if (vld) begin
      hist[d].push_back(x * (longint'(1) << shfv[d]));
      if (hist[d].size() > 64) void'(hist[d].pop_front());
      pval[d].push_back(ref_y(d));
      pdue[d].push_back(e + ordv[d]);
      if (exp_cnt[d] < ordv[d] * dlyv[d]) exp_cnt[d]++;
    end
    if (pdue[d].size() > 0 && pdue[d][0] == e) begin
      void'(pdue[d].pop_front());
      full = pval[d].pop_front();
      red  = reduce(full, sat);
      exp_vld[d] = 1;
      exp_out[d] = red;
      if (red != full) exp_ovf[d] = 1;
    end
  endtask

  task automatic check_outs();
    chk("a.out_valid", a_ov, longint'(exp_vld[0]));
    chk("a.primed", a_pr, longint'(exp_cnt[0] == ordv[0] * dlyv[0]));
    chk("a.ovf", a_ovf, longint'(exp_ovf[0]));
    if (exp_vld[0]) chk("a.out", a_out, exp_out[0]);
    chk("b.out_valid", b_ov, longint'(exp_vld[1]));
    chk("b.primed", b_pr, longint'(exp_cnt[1] == ordv[1] * dlyv[1]));
    chk("b.ovf", b_ovf, longint'(exp_ovf[1]));
    if (exp_vld[1]) chk("b.out", b_out, exp_out[1]);
    if (a_ov) seen[0].push_back(longint'(a_out));
    if (b_ov) seen[1].push_back(longint'(b_out));
  endtask

  task automatic tick();
    model_step(0, a_vld, longint'(a_in), a_sat, a_clr, cyc + 1);
    model_step(1, b_vld, longint'(b_in), b_sat, b_clr, cyc + 1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outs();
  endtask

  task automatic set_a(input bit v, input longint x, input bit s, input bit c);
    a_vld = v; a_in = W'(x); a_sat = s; a_clr = c;
  endtask

  task automatic set_b(input bit v, input longint x, input bit s, input bit c);
    b_vld = v; b_in = W'(x); b_sat = s; b_clr = c;
  endtask

  task automatic clear_all();
    set_a(0, 0, 1, 1);
    set_b(0, 0, 1, 1);
    tick();
    set_a(0, 0, 1, 0);
    set_b(0, 0, 1, 0);
    seen[0].delete();
    seen[1].delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [W-1:0] r16;
    bit sa, sb;
    ordv[0] = 2; dlyv[0] = 1; shfv[0] = 1;
    ordv[1] = 1; dlyv[1] = 4; shfv[1] = 0;
    model_reset();
    set_a(0, 0, 1, 0);
    set_b(0, 0, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst.a.out", a_out, 0);
    chk("rst.a.out_valid", a_ov, 0);
    chk("rst.a.primed", a_pr, 0);
    chk("rst.a.ovf", a_ovf, 0);
    chk("rst.b.out", b_out, 0);
    chk("rst.b.primed", b_pr, 0);
    rst = 1'b0;

    // Step on A, ramp on B
    for (int i = 0; i < 10; i++) begin
      set_a(i < 8, 100, 1, 0);
      set_b(i < 8, i, 1, 0);
      tick();
    end
    chk("step.0", seen[0][0], 200);
    chk("step.1", seen[0][1], -200);
    chk("step.2", seen[0][2], 0);
    chk("ramp.n", seen[1].size(), 8);
    chk("ramp.3", seen[1][3], 3);
    chk("ramp.6", seen[1][6], 4);

    // Gapped step
    clear_all();
    for (int i = 0; i < 12; i++) begin
      set_a((i % 3 == 0) && i < 9, 100, 1, 0);
      tick();
    end
    chk("gap.n", seen[0].size(), 3);
    chk("gap.0", seen[0][0], 200);
    chk("gap.1", seen[0][1], -200);
    chk("gap.2", seen[0][2], 0);

    // Full-scale alternation, saturating then wrapping
    for (int s = 1; s >= 0; s--) begin
      clear_all();
      for (int i = 0; i < 9; i++) begin
        set_a(i < 6, (i % 2) ? -32768 : 32767, s[0], 0);
        tick();
      end
      if (s == 1) begin
        chk("sat.0", seen[0][0], 32767);
        chk("sat.1", seen[0][1], -32768);
        chk("sat.ovf", a_ovf, 1);
      end else begin
        chk("wrap.0", seen[0][0], -2);
        chk("wrap.ovf", a_ovf, 1);
      end
    end

    // Clear with a sample offered on the same edge, pipeline in flight
    clear_all();
    for (int i = 0; i < 3; i++) begin
      set_a(1, 100, 1, 0);
      tick();
    end
    set_a(1, 100, 1, 1);
    tick();
    seen[0].delete();
    for (int i = 0; i < 4; i++) begin
      set_a(0, 0, 1, 0);
      tick();
    end
    chk("flush.n", seen[0].size(), 0);
    chk("flush.primed", a_pr, 0);
    chk("flush.ovf", a_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      set_a(i < 5, 100, 1, 0);
      tick();
    end
    chk("restep.0", seen[0][0], 200);
    chk("restep.1", seen[0][1], -200);
    chk("restep.2", seen[0][2], 0);

    // Random traffic with an asynchronous reset in the middle
    sa = 1; sb = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 20 == 0) sa = ~sa;
      if ($urandom % 20 == 0) sb = ~sb;
      r16 = W'($urandom);
      set_a($urandom % 10 < 7, ($urandom % 4 == 0) ? longint'(r16) : $urandom_range(0, 200) - 100,
            sa, $urandom % 100 == 0);
      r16 = W'($urandom);
      set_b($urandom % 10 < 7, ($urandom % 4 == 0) ? longint'(r16) : $urandom_range(0, 2000) - 1000,
            sb, $urandom % 100 == 0);
      tick();
      if (i == 300) begin
        #2 rst = 1'b1;
        #1;
        chk("arst.a.out", a_out, 0);
        chk("arst.a.out_valid", a_ov, 0);
        chk("arst.a.primed", a_pr, 0);
        chk("arst.a.ovf", a_ovf, 0);
        chk("arst.b.out", b_out, 0);
        chk("arst.b.out_valid", b_ov, 0);
        chk("arst.b.primed", b_pr, 0);
        chk("arst.b.ovf", b_ovf, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    set_a(0, 0, 1, 0);
    set_b(0, 0, 1, 0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
